// File: rtl/jogada_pkg.sv
// Shared constants, FSM state encoding and helpers for the play-input conditioner.
package jogada_pkg;

  localparam int unsigned LarguraChaves        = 4;
  localparam int unsigned DebounceCyclesPadrao = 3;

  // Codes are visible on db_estado, so the encoding is fixed.
  typedef enum logic [1:0] {
    StRepouso      = 2'd0,
    StEmite        = 2'd1,
    StInvalida     = 2'd2,
    StEsperaLibera = 2'd3
  } estado_e;

  function automatic logic eh_one_hot(input logic [LarguraChaves-1:0] v);
    return (v != '0) && ((v & (v - LarguraChaves'(1))) == '0);
  endfunction

endpackage

// File: rtl/debounce_jogada_if.sv
// Switch-in / play-out bundle between the board inputs, the conditioner and the game FSM.
interface debounce_jogada_if;

  logic                                enable;
  logic [jogada_pkg::LarguraChaves-1:0] chaves;
  logic [jogada_pkg::LarguraChaves-1:0] jogada;
  logic                                jogada_valida;
  logic                                jogada_invalida;
  logic [jogada_pkg::LarguraChaves-1:0] db_estavel;
  logic [1:0]                          db_estado;

  modport master (
    output enable, chaves,
    input  jogada, jogada_valida, jogada_invalida, db_estavel, db_estado
  );

  modport slave (
    input  enable, chaves,
    output jogada, jogada_valida, jogada_invalida, db_estavel, db_estado
  );

endinterface

// File: rtl/filtro_debounce.sv
// Two-flop synchroniser followed by a candidate/counter debounce filter.
module filtro_debounce #(
  parameter int unsigned Largura         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [Largura-1:0] i_dado,
  output logic [Largura-1:0] o_estavel,
  output logic               o_valido
);

  localparam int unsigned LarguraCont =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [LarguraCont-1:0] ContMax = LarguraCont'(DEBOUNCE_CYCLES - 1);

  logic [Largura-1:0]     r_sinc1;
  logic [Largura-1:0]     r_sinc;
  logic [Largura-1:0]     r_candidato;
  logic [Largura-1:0]     r_estavel;
  logic [LarguraCont-1:0] r_cont;
  logic [1:0]             r_pronto;
  logic                   r_valido;

  // r_pronto holds the filter off until r_sinc carries a post-reset sample, and r_valido
  // marks that estavel has been confirmed from real input at least once.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sinc1     <= '0;
      r_sinc      <= '0;
      r_candidato <= '0;
      r_estavel   <= '0;
      r_cont      <= '0;
      r_pronto    <= '0;
      r_valido    <= 1'b0;
    end else begin
      r_sinc1  <= i_dado;
      r_sinc   <= r_sinc1;
      r_pronto <= {r_pronto[0], 1'b1};
      if (!r_pronto[1]) begin
        r_candidato <= r_sinc;
        r_cont      <= '0;
      end else if (r_sinc != r_candidato) begin
        r_candidato <= r_sinc;
        r_cont      <= '0;
      end else if (r_cont < ContMax) begin
        r_cont <= r_cont + LarguraCont'(1);
      end else begin
        r_estavel <= r_candidato;
        r_valido  <= 1'b1;
      end
    end
  end

  assign o_estavel = r_estavel;
  assign o_valido  = r_valido;

endmodule

// File: rtl/debounce_jogada.sv
// Turns debounced switches into one registered one-hot play plus a single-cycle strobe per press.
module debounce_jogada
  import jogada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesPadrao
) (
  input logic                    i_clock,
  input logic                    i_reset,
  debounce_jogada_if.slave       io_jogada
);

  logic [LarguraChaves-1:0] w_estavel;
  logic                     w_valido;

  estado_e                  r_estado;
  logic [LarguraChaves-1:0] r_jogada;
  logic                     r_valida;
  logic                     r_invalida;

  filtro_debounce #(
    .Largura         (LarguraChaves),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_filtro (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_dado    (io_jogada.chaves),
    .o_estavel (w_estavel),
    .o_valido  (w_valido)
  );

  // Strobes are raised on the edge entering EMITE/INVALIDA so they coincide with that state.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_estado   <= StEsperaLibera;
      r_jogada   <= '0;
      r_valida   <= 1'b0;
      r_invalida <= 1'b0;
    end else begin
      r_valida   <= 1'b0;
      r_invalida <= 1'b0;
      unique case (r_estado)
        StRepouso: begin
          if (w_estavel == '0) begin
            r_estado <= StRepouso;
          end else if (eh_one_hot(w_estavel)) begin
            if (io_jogada.enable) begin
              r_estado <= StEmite;
              r_jogada <= w_estavel;
              r_valida <= 1'b1;
            end else begin
              r_estado <= StEsperaLibera;
            end
          end else begin
            r_estado   <= StInvalida;
            r_invalida <= 1'b1;
          end
        end
        StEmite:    r_estado <= StEsperaLibera;
        StInvalida: r_estado <= StEsperaLibera;
        StEsperaLibera: begin
          // A zero straight out of reset is not a confirmed release.
          if ((w_estavel == '0) && w_valido) begin
            r_estado <= StRepouso;
          end
        end
        default: r_estado <= StEsperaLibera;
      endcase
    end
  end

  assign io_jogada.jogada          = r_jogada;
  assign io_jogada.jogada_valida   = r_valida;
  assign io_jogada.jogada_invalida = r_invalida;
  assign io_jogada.db_estavel      = w_estavel;
  assign io_jogada.db_estado       = r_estado;

endmodule

// File: tb/tb_debounce_jogada.sv
// Directed bench for debounce_jogada: latency, bounce, invalid presses, enable and reset hold.
module tb_debounce_jogada;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  debounce_jogada_if u_if ();

  debounce_jogada #(
    .DEBOUNCE_CYCLES (3)
  ) u_dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .io_jogada (u_if)
  );

  int         n_checks   = 0;
  int         n_pass     = 0;
  int         cyc        = 0;
  int         n_val      = 0;
  int         n_inv      = 0;
  int         cyc_val    = -1;
  logic [3:0] ult_jogada = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.jogada_valida) begin
      n_val      <= n_val + 1;
      cyc_val    <= cyc;
      ult_jogada <= u_if.jogada;
    end
    if (u_if.jogada_invalida) n_inv <= n_inv + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  task automatic espera(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic joga(input logic [3:0] valor, input int on, input int off);
    u_if.chaves = valor;
    espera(on);
    u_if.chaves = 4'd0;
    espera(off);
  endtask

  int v0;
  int i0;
  int c0;
  int vb;
  logic [3:0] valor;

  initial begin
    u_if.enable = 1'b1;
    u_if.chaves = 4'd0;
    espera(1);
    check("reset_jogada", int'(u_if.jogada), 0);
    check("reset_valida", int'(u_if.jogada_valida), 0);
    check("reset_invalida", int'(u_if.jogada_invalida), 0);
    check("reset_estavel", int'(u_if.db_estavel), 0);
    check("reset_estado", int'(u_if.db_estado), 3);
    rst_n = 1'b1;
    espera(12);
    check("idle_estado", int'(u_if.db_estado), 0);

    // Single press, 5 cycles
    v0 = n_val;
    c0 = cyc;
    u_if.chaves = 4'b0001;
    espera(5);
    u_if.chaves = 4'd0;
    espera(20);
    check("p1_count", n_val - v0, 1);
    check("p1_latency", cyc_val - (c0 + 1), 6);
    check("p1_jogada_strobe", int'(ult_jogada), 1);
    check("p1_jogada_held", int'(u_if.jogada), 1);

    // Glitch of DEBOUNCE_CYCLES-1 samples
    v0 = n_val;
    i0 = n_inv;
    u_if.chaves = 4'b0100;
    espera(2);
    u_if.chaves = 4'd0;
    espera(15);
    check("glitch_val", n_val - v0, 0);
    check("glitch_inv", n_inv - i0, 0);
    check("glitch_jogada", int'(u_if.jogada), 1);

    // Bounce then settle
    v0 = n_val;
    for (int i = 0; i < 8; i++) begin
      u_if.chaves = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      espera(1);
    end
    check("bounce_quiet", n_val - v0, 0);
    c0 = cyc;
    u_if.chaves = 4'b0100;
    espera(10);
    u_if.chaves = 4'd0;
    espera(20);
    check("bounce_count", n_val - v0, 1);
    check("bounce_latency", cyc_val - (c0 + 1), 6);
    check("bounce_jogada", int'(u_if.jogada), 4);

    // Non-one-hot press
    v0 = n_val;
    i0 = n_inv;
    joga(4'b0011, 10, 20);
    check("inv_count", n_inv - i0, 1);
    check("inv_no_valid", n_val - v0, 0);
    check("inv_jogada", int'(u_if.jogada), 4);
    v0 = n_val;
    joga(4'b1000, 10, 20);
    check("after_inv_count", n_val - v0, 1);
    check("after_inv_jogada", int'(u_if.jogada), 8);

    // Press while disabled, enable raised while still held
    u_if.enable = 1'b0;
    v0 = n_val;
    u_if.chaves = 4'b0010;
    espera(8);
    u_if.enable = 1'b1;
    espera(2);
    u_if.chaves = 4'd0;
    espera(20);
    check("dis_count", n_val - v0, 0);
    check("dis_jogada", int'(u_if.jogada), 8);
    joga(4'b0010, 10, 20);
    check("en_count", n_val - v0, 1);
    check("en_jogada", int'(u_if.jogada), 2);

    // Switch held through reset release, then slide without release
    u_if.chaves = 4'b0001;
    rst_n = 1'b0;
    espera(2);
    check("rst2_jogada", int'(u_if.jogada), 0);
    check("rst2_estado", int'(u_if.db_estado), 3);
    rst_n = 1'b1;
    v0 = n_val;
    espera(15);
    check("hold_count", n_val - v0, 0);
    check("hold_estado", int'(u_if.db_estado), 3);
    check("hold_estavel", int'(u_if.db_estavel), 1);
    u_if.chaves = 4'b0010;
    espera(15);
    check("slide_count", n_val - v0, 0);
    check("slide_estavel", int'(u_if.db_estavel), 2);
    u_if.chaves = 4'd0;
    espera(20);
    joga(4'b0010, 10, 20);
    check("post_slide_count", n_val - v0, 1);
    check("post_slide_jogada", int'(u_if.jogada), 2);

    // Back-to-back plays
    v0 = n_val;
    for (int p = 0; p < 16; p++) begin
      valor = 4'b0001 << (p % 4);
      vb = n_val;
      joga(valor, 10, 10);
      check("b2b_count", n_val - vb, 1);
      check("b2b_jogada", int'(ult_jogada), int'(valor));
    end
    check("b2b_total", n_val - v0, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

endmodule
